ext_pipe: RTL and testbench

EXT_PIPE -- requirements
Module: ext_pipe

---
 rtl/ext_pipe_if.sv | 26 ++
 rtl/ext_pipe.sv | 103 ++++++++++
 tb/tb_ext_pipe.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_pipe_if.sv
// Handshake bundle for the immediate-extension pipeline: upstream operand
// channel, downstream result channel and the reserved-mode error counter.
interface ext_pipe_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IMM_W-1:0] imm;
    logic [2:0]       EOp;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] ext;
    logic             eop_err;
    logic [7:0]       err_cnt;

    modport master (
        output in_valid, imm, EOp, out_ready,
        input  in_ready, out_valid, ext, eop_err, err_cnt
    );

    modport slave (
        input  in_valid, imm, EOp, out_ready,
        output in_ready, out_valid, ext, eop_err, err_cnt
    );
endinterface

// File: rtl/ext_pipe.sv
// Two-stage immediate extender: S1 captures the operand, S2 holds the
// extended result; both stages advance under valid/ready back-pressure.
module ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic        clk,
    input  logic        reset,
    ext_pipe_if.slave   bus
);
    localparam logic [2:0] EOP_SEXT  = 3'b000;
    localparam logic [2:0] EOP_ZEXT  = 3'b001;
    localparam logic [2:0] EOP_UPPER = 3'b010;
    localparam logic [2:0] EOP_BROFF = 3'b011;
    localparam logic [2:0] EOP_SBYTE = 3'b100;
    localparam logic [2:0] EOP_ZBYTE = 3'b101;

    logic             s1_valid_reg;
    logic [IMM_W-1:0] s1_imm_reg;
    logic [2:0]       s1_eop_reg;

    logic             s2_valid_reg;
    logic [OUT_W-1:0] s2_ext_reg;
    logic             s2_err_reg;

    logic [7:0]       err_cnt_reg;

    logic             s2_load;
    logic             in_fire;
    logic             out_fire;
    logic [OUT_W-1:0] ext_next;
    logic             err_next;

    logic signed [IMM_W-1:0] imm_s;
    logic signed [7:0]       byte_s;

    // S2 can take S1 whenever it is empty or its result leaves this cycle.
    assign s2_load  = s1_valid_reg && (!s2_valid_reg || bus.out_ready);
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_valid_reg && bus.out_ready;

    assign bus.in_ready  = !s1_valid_reg || s2_load;
    assign bus.out_valid = s2_valid_reg;
    assign bus.ext       = s2_ext_reg;
    assign bus.eop_err   = s2_err_reg;
    assign bus.err_cnt   = err_cnt_reg;

    assign imm_s  = s1_imm_reg;
    assign byte_s = s1_imm_reg[7:0];

    // Size casts of signed operands sign-extend; unsigned ones zero-extend.
    always_comb begin
        ext_next = '0;
        err_next = 1'b0;
        case (s1_eop_reg)
            EOP_SEXT:  ext_next = OUT_W'(imm_s);
            EOP_ZEXT:  ext_next = OUT_W'(s1_imm_reg);
            EOP_UPPER: ext_next = OUT_W'(s1_imm_reg) << (OUT_W - IMM_W);
            EOP_BROFF: ext_next = OUT_W'(imm_s) << SHAMT;
            EOP_SBYTE: ext_next = OUT_W'(byte_s);
            EOP_ZBYTE: ext_next = OUT_W'(s1_imm_reg[7:0]);
            default:   err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_imm_reg   <= '0;
            s1_eop_reg   <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_imm_reg   <= bus.imm;
            s1_eop_reg   <= bus.EOp;
        end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_ext_reg   <= '0;
            s2_err_reg   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= 1'b1;
            s2_ext_reg   <= ext_next;
            s2_err_reg   <= err_next;
        end else if (out_fire) begin
            s2_valid_reg <= 1'b0;
        end
    end

    // Counts delivered reserved-mode results, sticking at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_reg <= 8'd0;
        end else if (out_fire && s2_err_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end
endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboarded bench for ext_pipe: stimulus pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares outputs.
module tb_ext_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ext_pipe_if #(.IMM_W(16), .OUT_W(32)) bus ();
    ext_pipe #(.IMM_W(16), .OUT_W(32), .SHAMT(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    ext_pipe_if #(.IMM_W(8), .OUT_W(16)) bus2 ();
    ext_pipe #(.IMM_W(8), .OUT_W(16), .SHAMT(1)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct {
        logic [31:0] ext;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] outq[$];
    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    int          model_cnt = 0;
    int          ordy_pct = 100;
    int          n_out = 0;
    bit          lat_check = 0;
    bit          hold_pend = 0;
    logic [31:0] hold_ext;
    logic        hold_err;
    exp_t        mon_e;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endfunction

    // Reference model: value arithmetic on the immediate, then wrap to 32 bits.
    function automatic exp_t model(input logic [15:0] im, input logic [2:0] op);
        exp_t   e;
        longint v;
        longint sv;
        e.err = 1'b0;
        e.cyc = 0;
        sv = (im >= 16'h8000) ? longint'(im) - 65536 : longint'(im);
        case (op)
            3'd0: v = sv;
            3'd1: v = longint'(im);
            3'd2: v = longint'(im) * 65536;
            3'd3: v = sv * 4;
            3'd4: begin
                v = longint'(im) % 256;
                if (v >= 128) v = v - 256;
            end
            3'd5: v = longint'(im) % 256;
            default: begin
                v = 0;
                e.err = 1'b1;
            end
        endcase
        e.ext = v[31:0];
        return e;
    endfunction

    // Monitor: transfers decided at the next rising edge are visible here.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            sb.delete();
            model_cnt = 0;
            hold_pend = 0;
        end else begin
            check(bus.err_cnt == 8'(model_cnt), "err_cnt", 64'(bus.err_cnt), 64'(model_cnt));
            if (hold_pend) begin
                check(bus.out_valid && bus.ext == hold_ext && bus.eop_err == hold_err,
                      "stall_hold", 64'({bus.out_valid, bus.eop_err, bus.ext}),
                      64'({1'b1, hold_err, hold_ext}));
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_ext  = bus.ext;
            hold_err  = bus.eop_err;
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                $display("out %0d: ext=%h eop_err=%b err_cnt=%0d", n_out, bus.ext, bus.eop_err, bus.err_cnt);
                outq.push_back(bus.ext);
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_out", 64'(bus.ext), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check(bus.ext == mon_e.ext, "ext", 64'(bus.ext), 64'(mon_e.ext));
                    check(bus.eop_err == mon_e.err, "eop_err", 64'(bus.eop_err), 64'(mon_e.err));
                    if (lat_check)
                        check(cyc - mon_e.cyc == 2, "latency", 64'(cyc - mon_e.cyc), 64'(2));
                    if (mon_e.err && model_cnt < 255) model_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e = model(bus.imm, bus.EOp);
                mon_e.cyc = cyc;
                sb.push_back(mon_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] im, input logic [2:0] op);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.imm      = im;
        bus.EOp      = op;
        for (int k = 0; k < 200 && !acc; k++) begin
            bus.out_ready = ($urandom_range(99) < ordy_pct);
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check(1'b0, "send_timeout", 64'(0), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.out_ready = ($urandom_range(99) < ordy_pct);
            step();
        end
    endtask

    task automatic drain();
        int k;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (k = 0; k < 60; k++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            step();
        end
        if (k == 60) check(1'b0, "drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    function automatic logic [15:0] rand_imm();
        case ($urandom_range(4))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0080 ^ 16'($urandom_range(1));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            ordy_pct = (i % 50 < 25) ? 70 : 30;
            if ($urandom_range(3) != 0) send(rand_imm(), 3'($urandom_range(7)));
            else idle(1);
        end
    endtask

    logic [31:0] tbl_exp[4];
    logic [15:0] t2_exp[5];
    logic [2:0]  t2_op[5];
    int          accepts;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.imm = 16'h1234; bus.EOp = 3'd0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.imm = 8'h00; bus2.EOp = 3'd0; bus2.out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check(bus.out_valid == 1'b0, "reset_out_valid", 64'(bus.out_valid), 64'(0));
        check(bus.in_ready == 1'b1, "reset_in_ready", 64'(bus.in_ready), 64'(1));
        check(bus.err_cnt == 8'd0, "reset_err_cnt", 64'(bus.err_cnt), 64'(0));
        step();

        // Narrow configuration: 8-bit immediate into 16 bits, shift by 1.
        t2_op[0] = 3'd3; t2_exp[0] = 16'hFF02;
        t2_op[1] = 3'd0; t2_exp[1] = 16'hFF81;
        t2_op[2] = 3'd2; t2_exp[2] = 16'h8100;
        t2_op[3] = 3'd4; t2_exp[3] = 16'hFF81;
        t2_op[4] = 3'd1; t2_exp[4] = 16'h0081;
        for (int i = 0; i < 5; i++) begin
            int k;
            bus2.in_valid = 1'b1; bus2.imm = 8'h81; bus2.EOp = t2_op[i];
            step();
            bus2.in_valid = 1'b0;
            for (k = 0; k < 10; k++) begin
                if (bus2.out_valid) break;
                step();
            end
            check(bus2.out_valid && bus2.ext == t2_exp[i] && !bus2.eop_err, "narrow_ext",
                  64'({bus2.out_valid, bus2.eop_err, bus2.ext}), 64'({1'b1, 1'b0, t2_exp[i]}));
            step();
        end

        // Consecutive modes 0..3 on 8001 with downstream always ready.
        lat_check = 1;
        ordy_pct = 100;
        outq.delete();
        tbl_exp[0] = 32'hFFFF8001; tbl_exp[1] = 32'h00008001;
        tbl_exp[2] = 32'h80010000; tbl_exp[3] = 32'hFFFE0004;
        for (int i = 0; i < 4; i++) send(16'h8001, 3'(i));
        drain();
        for (int i = 0; i < 4; i++)
            check(outq.size() > i && outq[i] == tbl_exp[i], "mode_vec",
                  64'(outq.size() > i ? outq[i] : 32'hDEAD), 64'(tbl_exp[i]));

        outq.delete();
        send(16'h0080, 3'd4);
        send(16'h0080, 3'd5);
        drain();
        check(outq.size() == 2 && outq[0] == 32'hFFFFFF80, "byte_sext", 64'(outq[0]), 64'(32'hFFFFFF80));
        check(outq.size() == 2 && outq[1] == 32'h00000080, "byte_zext", 64'(outq[1]), 64'(32'h00000080));

        outq.delete();
        send(16'hFFFF, 3'd6);
        drain();
        check(outq.size() == 1 && outq[0] == 32'd0, "reserved_ext", 64'(outq[0]), 64'(0));
        check(bus.err_cnt == 8'd1, "err_cnt_one", 64'(bus.err_cnt), 64'(1));
        for (int i = 0; i < 299; i++) send(16'($urandom), 3'(6 + $urandom_range(1)));
        drain();
        check(bus.err_cnt == 8'd255, "err_cnt_sat", 64'(bus.err_cnt), 64'(255));
        lat_check = 0;

        // Stall: downstream blocked for 5 cycles while upstream keeps offering.
        accepts = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.imm = 16'($urandom); bus.EOp = 3'($urandom_range(5));
            #1;
            if (bus.in_ready) accepts++;
            step();
        end
        bus.in_valid = 1'b0;
        check(accepts == 2, "stall_accepts", 64'(accepts), 64'(2));
        check(bus.in_ready == 1'b0, "stall_in_ready", 64'(bus.in_ready), 64'(0));
        drain();

        random_phase(400);
        drain();

        // Reset with both stages full and an input offered in the reset cycle.
        ordy_pct = 0;
        send(16'h1111, 3'd7);
        send(16'h2222, 3'd0);
        bus.out_ready = 1'b0;
        #1;
        check(bus.in_ready == 1'b0 && bus.out_valid, "full_before_reset",
              64'({bus.in_ready, bus.out_valid}), 64'(2'b01));
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.imm = 16'h3333; bus.EOp = 3'd6;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check(bus.out_valid == 1'b0, "rst_full_out_valid", 64'(bus.out_valid), 64'(0));
        check(bus.in_ready == 1'b1, "rst_full_in_ready", 64'(bus.in_ready), 64'(1));
        check(bus.err_cnt == 8'd0, "rst_full_err_cnt", 64'(bus.err_cnt), 64'(0));
        ordy_pct = 100;
        idle(3);
        check(bus.out_valid == 1'b0, "no_stale_out", 64'(bus.out_valid), 64'(0));

        random_phase(150);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
